tile_move_controller: RTL and testbench
=======================================

Name: tile_move_controller

Overview:
- Upstream sequencer for the current-tile memory. It spawns tiles, turns player commands and a gravity timer into position and angle updates, and locks landed tiles.
- Consumes the tile memory's ready/move-availability outputs and drives its set/fetch/empty inputs.
- On landing, raises a commit handshake to the matrix-merge/line-clear stage, then spawns the next tile.
- Detects game over.

Parameters:
- gravity_period_p, 25000000, cycles between automatic down moves (≥2).
- spawn_x_p, 3, x of spawn point.
- spawn_y_p, 0, y of spawn point.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset; asynchronous, active-high.
- cmd_i  in  3  move_cmd_e: eCmdNone/eCmdLeft/eCmdRight/eCmdDown/eCmdRotate/eCmdHardDrop.
- cmd_v_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when cmd_v_i & cmd_ready_o.
- ctm_ready_i  in  1  tile memory idle, judgement complete.
- ctm_move_avail_i  in  4  [0]left [1]right [2]down [3]rotate.
- ctm_pos_i  in  point_t  current tile position.
- ctm_type_i  in  tile_type_e  current type.
- ctm_angle_i  in  2  current angle.
- ctm_next_type_i  in  tile_type_e  queued next type.
- ctm_next_angle_i  in  2  queued next angle.
- ctm_pos_o  out  point_t  new position.
- ctm_pos_v_o  out  1  new-position strobe.
- ctm_type_o  out  tile_type_e  type to load.
- ctm_angle_o  out  2  angle to load.
- ctm_type_v_o  out  1  type/angle strobe.
- ctm_fetch_next_o  out  1  advance next-tile generator.
- ctm_empty_o  out  1  clear current tile.
- commit_v_o  out  1  landed tile ready to merge.
- commit_ready_i  in  1  merge stage accepts.
- game_over_o  out  1  sticky game-over flag.

Behaviour:
- Reset values:
  - state = eStart.
  - All strobes 0; commit_v_o = 0; game_over_o = 0; cmd_ready_o = 0.
  - gravity counter = 0; pending = 0.
  - ctm_pos_o = {spawn_x_p, spawn_y_p}; ctm_type_o = eNon; ctm_angle_o = 0.
- Strobes (pos_v, type_v, fetch_next, empty) are single-cycle and only issued in a cycle where ctm_ready_i = 1.
- ctm_type_o/ctm_angle_o default to ctm_type_i/ctm_angle_i whenever not spawning or rotating.
- eStart: wait ctm_ready_i → eSpawn.
- eSpawn:
  - Action: drive type = ctm_next_type_i, angle = ctm_next_angle_i, type_v = 1, pos = spawn point, pos_v = 1 in the same cycle.
  - Next: eFetch.
- eFetch: wait ctm_ready_i; pulse ctm_fetch_next_o → eWaitJudge.
- eWaitJudge: wait ctm_ready_i = 1 (≥4 cycles after any strobe); avail bits then valid → eRun.
- eRun:
  - cmd_ready_o = 1 only here, and only when gravity pending = 0.
  - Priority: pending gravity over user command.
  - Left/right/down/rotate with avail bit set:
    - Left: pos_v with x−1. Right: pos_v with x+1. Down: pos_v with y+1.
    - Rotate: type_v with ctm_type_i and angle+1 (2-bit wrap, 3→0).
    - Next: eWaitJudge.
  - Left/right/rotate with avail bit clear: command consumed, no strobe, stay in eRun.
  - Down (user or gravity) with avail[2] = 0:
    - If ctm_pos_i.y_m == spawn_y_p → eOver.
    - Else → eLock.
  - eCmdNone: consumed, no effect.
- Gravity:
  - Counter increments only in eRun.
  - At gravity_period_p−1: set pending, counter = 0.
  - Any successful down move clears the counter and pending.
  - Pending is cleared when served.
- eLock: commit_v_o = 1 until commit_ready_i. On handshake, pulse ctm_empty_o → eStart.
- eOver: game_over_o = 1, cmd_ready_o = 0; no strobes; left only by reset.
- Reset asserted mid-handshake drops commit_v_o immediately (asynchronous); no partial strobe survives.
- cmd_v_i while cmd_ready_o = 0 is held by the sender, never dropped.

Optional Feature:
- Macro: TILE_MOVE_HARD_DROP_EN.
- Enabled:
  - eCmdHardDrop enters eDrop, which issues a down move each time ctm_ready_i returns while avail[2] = 1.
  - When avail[2] = 0: lock (or game over per the spawn-row rule). Gravity is frozen.
- Disabled: eCmdHardDrop is consumed as a no-op; eDrop is not built.

Decomposition:
- Package tetris:
  - move_cmd_e.
  - Controller state enum ctrl_state_e.
  - Bit-index constants mv_left/mv_right/mv_down/mv_rotate_c.
  - Existing point_t and tile_type_e.
- One sub-module: gravity_timer (counter + pending flag, clear/enable inputs).

Test Plan:
- Reset release, ctm_ready_i = 1, next = (eT, 2): one cycle with type_v = 1, pos_v = 1, pos = (3,0), angle = 2; then fetch_next pulse; then eRun after ready.
- eRun at pos (5,7), avail = 4'b1111, cmd Left: pos_v with (4,7); cmd Rotate at angle 3: type_v with angle 0.
- avail[0] = 0, cmd Left: accepted, no strobe, state unchanged.
- gravity_period_p = 4, no commands: down strobe every 4 eRun cycles (plus judge time); a concurrent cmd sees cmd_ready_o = 0 in the pending cycle.
- pos (4,10), avail[2] = 0, down: commit_v_o rises; commit_ready_i held low 3 cycles then high → ctm_empty_o one pulse, then a new spawn.
- Spawned tile with avail[2] = 0 at y = 0: game_over_o = 1 and stays; cmd_ready_o = 0; async reset clears it.

Source files
------------

// File: rtl/tile_move_controller_pkg.sv
// Shared types for the current-tile move controller: commands, tile types,
// board coordinates, controller states and move-availability bit indices.
package tile_move_controller_pkg;

    typedef enum logic [2:0] {
        eCmdNone,
        eCmdLeft,
        eCmdRight,
        eCmdDown,
        eCmdRotate,
        eCmdHardDrop
    } move_cmd_e;

    typedef enum logic [2:0] {
        eNon,
        eI,
        eO,
        eT,
        eS,
        eZ,
        eJ,
        eL
    } tile_type_e;

    localparam int pos_x_w_c = 4;
    localparam int pos_y_w_c = 5;

    typedef struct packed {
        logic [pos_x_w_c-1:0] x_m;
        logic [pos_y_w_c-1:0] y_m;
    } point_t;

    typedef enum logic [2:0] {
        eStart,
        eSpawn,
        eFetch,
        eWaitJudge,
        eRun,
        eLock,
        eDrop,
        eOver
    } ctrl_state_e;

    localparam int mv_left_c   = 0;
    localparam int mv_right_c  = 1;
    localparam int mv_down_c   = 2;
    localparam int mv_rotate_c = 3;

    // Minimum cycles the tile memory needs after a strobe before its
    // availability bits describe the new position.
    localparam logic [2:0] judge_wait_c = 3'd4;

    function automatic point_t move_point(input point_t p, input move_cmd_e cmd);
        point_t r;
        r = p;
        case (cmd)
            eCmdLeft:  r.x_m = p.x_m - 4'd1;
            eCmdRight: r.x_m = p.x_m + 4'd1;
            eCmdDown:  r.y_m = p.y_m + 5'd1;
            default:   r = p;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tile_move_controller_gravity_timer.sv
// Gravity tick generator: counts enabled cycles and raises a pending flag
// every period_p cycles; the flag holds until served or cleared.
module tile_move_controller_gravity_timer #(
    parameter int unsigned period_p = 25000000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic en_i,
    input  logic clr_i,
    input  logic served_i,
    output logic pending_o
);

    localparam int unsigned cnt_w_lp = $clog2(period_p);
    localparam logic [cnt_w_lp-1:0] last_lp = cnt_w_lp'(period_p - 1);

    logic [cnt_w_lp-1:0] cnt_q, cnt_d;
    logic                pending_q, pending_d;

    always_comb begin
        cnt_d     = cnt_q;
        pending_d = pending_q;
        if (served_i) begin
            pending_d = 1'b0;
        end
        if (en_i) begin
            if (cnt_q == last_lp) begin
                cnt_d     = '0;
                pending_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // A successful down move restarts the whole period.
        if (clr_i) begin
            cnt_d     = '0;
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/tile_move_controller.sv
// Current-tile sequencer: spawn, move/rotate, gravity, lock and game over.
// Optional hard drop is built when TILE_MOVE_HARD_DROP_EN is defined.
module tile_move_controller
    import tile_move_controller_pkg::*;
#(
    parameter int unsigned gravity_period_p = 25000000,
    parameter int unsigned spawn_x_p        = 3,
    parameter int unsigned spawn_y_p        = 0
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  move_cmd_e   cmd_i,
    input  logic        cmd_v_i,
    output logic        cmd_ready_o,
    input  logic        ctm_ready_i,
    input  logic [3:0]  ctm_move_avail_i,
    input  point_t      ctm_pos_i,
    input  tile_type_e  ctm_type_i,
    input  logic [1:0]  ctm_angle_i,
    input  tile_type_e  ctm_next_type_i,
    input  logic [1:0]  ctm_next_angle_i,
    output point_t      ctm_pos_o,
    output logic        ctm_pos_v_o,
    output tile_type_e  ctm_type_o,
    output logic [1:0]  ctm_angle_o,
    output logic        ctm_type_v_o,
    output logic        ctm_fetch_next_o,
    output logic        ctm_empty_o,
    output logic        commit_v_o,
    input  logic        commit_ready_i,
    output logic        game_over_o,
    output ctrl_state_e state_o
);

    localparam logic [pos_x_w_c-1:0] spawn_x_lp = pos_x_w_c'(spawn_x_p);
    localparam logic [pos_y_w_c-1:0] spawn_y_lp = pos_y_w_c'(spawn_y_p);
    localparam point_t spawn_pt_lp = '{x_m: spawn_x_lp, y_m: spawn_y_lp};

    ctrl_state_e state_q, state_d;
    point_t      pos_q, pos_d;
    tile_type_e  type_q, type_d;
    logic [1:0]  angle_q, angle_d;
    logic        pos_v_q, pos_v_d;
    logic        type_v_q, type_v_d;
    logic        fetch_q, fetch_d;
    logic        empty_q, empty_d;
    logic        commit_v_q, commit_v_d;
    logic        game_over_q, game_over_d;
    logic [2:0]  judge_cnt_q, judge_cnt_d;

    logic grav_pending, grav_en, grav_clr, grav_served;
    logic try_down;

    // Handshakes: a command transfers on a cycle where cmd_v_i & cmd_ready_o,
    // and the sender holds cmd_i/cmd_v_i until then; a commit transfers on a
    // cycle where commit_v_o & commit_ready_i, with commit_v_o held until then.
    assign cmd_ready_o = (state_q == eRun) && !grav_pending && ctm_ready_i;
    assign grav_en     = (state_q == eRun);

    tile_move_controller_gravity_timer #(
        .period_p (gravity_period_p)
    ) u_gravity (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .en_i      (grav_en),
        .clr_i     (grav_clr),
        .served_i  (grav_served),
        .pending_o (grav_pending)
    );

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        type_d      = ctm_type_i;
        angle_d     = ctm_angle_i;
        pos_v_d     = 1'b0;
        type_v_d    = 1'b0;
        fetch_d     = 1'b0;
        empty_d     = 1'b0;
        commit_v_d  = commit_v_q;
        game_over_d = game_over_q;
        judge_cnt_d = 3'd0;
        grav_clr    = 1'b0;
        grav_served = 1'b0;
        try_down    = 1'b0;

        case (state_q)
            eStart: begin
                if (ctm_ready_i) state_d = eSpawn;
            end
            eSpawn: begin
                if (ctm_ready_i) begin
                    type_d   = ctm_next_type_i;
                    angle_d  = ctm_next_angle_i;
                    type_v_d = 1'b1;
                    pos_d    = spawn_pt_lp;
                    pos_v_d  = 1'b1;
                    state_d  = eFetch;
                end
            end
            eFetch: begin
                if (ctm_ready_i) begin
                    fetch_d = 1'b1;
                    state_d = eWaitJudge;
                end
            end
            eWaitJudge: begin
                if (judge_cnt_q >= judge_wait_c && ctm_ready_i) begin
                    state_d = eRun;
                end else begin
                    judge_cnt_d = (judge_cnt_q >= judge_wait_c) ? judge_cnt_q : judge_cnt_q + 3'd1;
                end
            end
            eRun: begin
                if (ctm_ready_i) begin
                    if (grav_pending) begin
                        grav_served = 1'b1;
                        try_down    = 1'b1;
                    end else if (cmd_v_i) begin
                        case (cmd_i)
                            eCmdLeft: begin
                                if (ctm_move_avail_i[mv_left_c]) begin
                                    pos_d   = move_point(ctm_pos_i, eCmdLeft);
                                    pos_v_d = 1'b1;
                                    state_d = eWaitJudge;
                                end
                            end
                            eCmdRight: begin
                                if (ctm_move_avail_i[mv_right_c]) begin
                                    pos_d   = move_point(ctm_pos_i, eCmdRight);
                                    pos_v_d = 1'b1;
                                    state_d = eWaitJudge;
                                end
                            end
                            eCmdDown: try_down = 1'b1;
                            eCmdRotate: begin
                                if (ctm_move_avail_i[mv_rotate_c]) begin
                                    angle_d  = ctm_angle_i + 2'd1;
                                    type_v_d = 1'b1;
                                    state_d  = eWaitJudge;
                                end
                            end
`ifdef TILE_MOVE_HARD_DROP_EN
                            eCmdHardDrop: state_d = eDrop;
`endif
                            default: ;
                        endcase
                    end
                end
            end
`ifdef TILE_MOVE_HARD_DROP_EN
            eDrop: begin
                if (judge_cnt_q >= judge_wait_c && ctm_ready_i) begin
                    try_down = 1'b1;
                end else begin
                    judge_cnt_d = (judge_cnt_q >= judge_wait_c) ? judge_cnt_q : judge_cnt_q + 3'd1;
                end
            end
`endif
            eLock: begin
                // The tile memory has been idle since the lock decision, so
                // the clear strobe can follow the handshake directly.
                if (commit_v_q && commit_ready_i) begin
                    commit_v_d = 1'b0;
                    empty_d    = 1'b1;
                    state_d    = eStart;
                end
            end
            eOver: begin
                game_over_d = 1'b1;
            end
            default: state_d = eStart;
        endcase

        if (try_down) begin
            if (ctm_move_avail_i[mv_down_c]) begin
                pos_d    = move_point(ctm_pos_i, eCmdDown);
                pos_v_d  = 1'b1;
                grav_clr = 1'b1;
                state_d  = (state_q == eDrop) ? eDrop : eWaitJudge;
            end else if (ctm_pos_i.y_m == spawn_y_lp) begin
                state_d     = eOver;
                game_over_d = 1'b1;
            end else begin
                state_d    = eLock;
                commit_v_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= eStart;
            pos_q       <= spawn_pt_lp;
            type_q      <= eNon;
            angle_q     <= 2'd0;
            pos_v_q     <= 1'b0;
            type_v_q    <= 1'b0;
            fetch_q     <= 1'b0;
            empty_q     <= 1'b0;
            commit_v_q  <= 1'b0;
            game_over_q <= 1'b0;
            judge_cnt_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            type_q      <= type_d;
            angle_q     <= angle_d;
            pos_v_q     <= pos_v_d;
            type_v_q    <= type_v_d;
            fetch_q     <= fetch_d;
            empty_q     <= empty_d;
            commit_v_q  <= commit_v_d;
            game_over_q <= game_over_d;
            judge_cnt_q <= judge_cnt_d;
        end
    end

    assign ctm_pos_o        = pos_q;
    assign ctm_pos_v_o      = pos_v_q;
    assign ctm_type_o       = type_q;
    assign ctm_angle_o      = angle_q;
    assign ctm_type_v_o     = type_v_q;
    assign ctm_fetch_next_o = fetch_q;
    assign ctm_empty_o      = empty_q;
    assign commit_v_o       = commit_v_q;
    assign game_over_o      = game_over_q;
    assign state_o          = state_q;

endmodule

// File: tb/tb_tile_move_controller.sv
// Directed bench for tile_move_controller: a fast-gravity instance for the
// gravity timing and a slow-gravity instance for commands, lock and game over.
module tb_tile_move_controller;
    import tile_move_controller_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    move_cmd_e   cmd;
    logic        cmd_v, cmd_ready, ctm_ready, commit_ready;
    logic [3:0]  avail;
    point_t      pos_in;
    tile_type_e  type_in, next_type;
    logic [1:0]  angle_in, next_angle;
    point_t      pos_out;
    tile_type_e  type_out;
    logic [1:0]  angle_out;
    logic        pos_v, type_v, fetch, empty, commit_v, game_over;
    ctrl_state_e state;

    move_cmd_e   g_cmd;
    logic        g_cmd_v, g_cmd_ready;
    logic [3:0]  g_avail;
    point_t      g_pos_in, g_pos_out;
    tile_type_e  g_type_out;
    logic [1:0]  g_angle_out;
    logic        g_pos_v, g_type_v, g_fetch, g_empty, g_commit_v, g_game_over;
    ctrl_state_e g_state;

    tile_move_controller #(.gravity_period_p(1000), .spawn_x_p(3), .spawn_y_p(0)) u_dut (
        .clk_i(clk), .reset_i(reset), .cmd_i(cmd), .cmd_v_i(cmd_v), .cmd_ready_o(cmd_ready),
        .ctm_ready_i(ctm_ready), .ctm_move_avail_i(avail), .ctm_pos_i(pos_in),
        .ctm_type_i(type_in), .ctm_angle_i(angle_in), .ctm_next_type_i(next_type),
        .ctm_next_angle_i(next_angle), .ctm_pos_o(pos_out), .ctm_pos_v_o(pos_v),
        .ctm_type_o(type_out), .ctm_angle_o(angle_out), .ctm_type_v_o(type_v),
        .ctm_fetch_next_o(fetch), .ctm_empty_o(empty), .commit_v_o(commit_v),
        .commit_ready_i(commit_ready), .game_over_o(game_over), .state_o(state)
    );

    tile_move_controller #(.gravity_period_p(4), .spawn_x_p(3), .spawn_y_p(0)) u_grav (
        .clk_i(clk), .reset_i(reset), .cmd_i(g_cmd), .cmd_v_i(g_cmd_v), .cmd_ready_o(g_cmd_ready),
        .ctm_ready_i(ctm_ready), .ctm_move_avail_i(g_avail), .ctm_pos_i(g_pos_in),
        .ctm_type_i(type_in), .ctm_angle_i(angle_in), .ctm_next_type_i(next_type),
        .ctm_next_angle_i(next_angle), .ctm_pos_o(g_pos_out), .ctm_pos_v_o(g_pos_v),
        .ctm_type_o(g_type_out), .ctm_angle_o(g_angle_out), .ctm_type_v_o(g_type_v),
        .ctm_fetch_next_o(g_fetch), .ctm_empty_o(g_empty), .commit_v_o(g_commit_v),
        .commit_ready_i(commit_ready), .game_over_o(g_game_over), .state_o(g_state)
    );

    typedef struct {
        move_cmd_e   cmd;
        logic [3:0]  avail;
        logic [3:0]  x;
        logic [4:0]  y;
        logic [1:0]  ang;
        logic        exp_pos_v;
        logic        exp_type_v;
        logic [3:0]  exp_x;
        logic [4:0]  exp_y;
        logic [1:0]  exp_ang;
        ctrl_state_e exp_state;
    } vec_t;

    localparam int n_vecs_c = 11;
    vec_t vecs[n_vecs_c];

    int n_vec = 0;
    int n_err = 0;

    function automatic point_t pt(input logic [3:0] x, input logic [4:0] y);
        point_t p;
        p.x_m = x;
        p.y_m = y;
        return p;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_run(input string name);
        int n = 0;
        while (state != eRun && n < 40) begin
            tick();
            n++;
        end
        check(name, 32'(state), 32'(eRun));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; cmd = eCmdNone; cmd_v = 1'b0; ctm_ready = 1'b1; avail = 4'b1111;
        pos_in = pt(4'd3, 5'd0); type_in = eT; angle_in = 2'd0;
        next_type = eT; next_angle = 2'd2; commit_ready = 1'b0;
        g_cmd = eCmdNone; g_cmd_v = 1'b0; g_avail = 4'b1111; g_pos_in = pt(4'd3, 5'd5);

        vecs[0]  = '{eCmdLeft,     4'b1111, 4'd5, 5'd7,  2'd0, 1'b1, 1'b0, 4'd4, 5'd7,  2'd0, eWaitJudge};
        vecs[1]  = '{eCmdRight,    4'b1111, 4'd5, 5'd7,  2'd1, 1'b1, 1'b0, 4'd6, 5'd7,  2'd1, eWaitJudge};
        vecs[2]  = '{eCmdDown,     4'b1111, 4'd5, 5'd7,  2'd2, 1'b1, 1'b0, 4'd5, 5'd8,  2'd2, eWaitJudge};
        vecs[3]  = '{eCmdRotate,   4'b1111, 4'd5, 5'd7,  2'd3, 1'b0, 1'b1, 4'd0, 5'd0,  2'd0, eWaitJudge};
        vecs[4]  = '{eCmdRotate,   4'b1111, 4'd5, 5'd7,  2'd1, 1'b0, 1'b1, 4'd0, 5'd0,  2'd2, eWaitJudge};
        vecs[5]  = '{eCmdLeft,     4'b1110, 4'd5, 5'd7,  2'd0, 1'b0, 1'b0, 4'd0, 5'd0,  2'd0, eRun};
        vecs[6]  = '{eCmdRight,    4'b1101, 4'd5, 5'd7,  2'd1, 1'b0, 1'b0, 4'd0, 5'd0,  2'd1, eRun};
        vecs[7]  = '{eCmdRotate,   4'b0111, 4'd5, 5'd7,  2'd2, 1'b0, 1'b0, 4'd0, 5'd0,  2'd2, eRun};
        vecs[8]  = '{eCmdNone,     4'b1111, 4'd5, 5'd7,  2'd3, 1'b0, 1'b0, 4'd0, 5'd0,  2'd3, eRun};
        vecs[9]  = '{eCmdHardDrop, 4'b1111, 4'd5, 5'd7,  2'd0, 1'b0, 1'b0, 4'd0, 5'd0,  2'd0, eRun};
        vecs[10] = '{eCmdDown,     4'b1111, 4'd9, 5'd18, 2'd1, 1'b1, 1'b0, 4'd9, 5'd19, 2'd1, eWaitJudge};

        // Gravity instance: period 4, no commands except one held across a pending cycle.
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (7) tick();
        check("g_judge_hold", 32'(g_state), 32'(eWaitJudge));
        tick();
        check("g_run_entry", 32'(g_state), 32'(eRun));
        repeat (3) tick();
        check("g_ready_before_pend", 32'(g_cmd_ready), 32'd1);
        check("g_no_early_down", 32'(g_pos_v), 32'd0);
        tick();
        check("g_ready_pending", 32'(g_cmd_ready), 32'd0);
        g_cmd = eCmdLeft;
        g_cmd_v = 1'b1;
        tick();
        check("g_grav_down_v", 32'(g_pos_v), 32'd1);
        check("g_grav_down_pos", 32'(g_pos_out), 32'(pt(4'd3, 5'd6)));
        repeat (5) tick();
        check("g_run_again", 32'(g_state), 32'(eRun));
        check("g_ready_again", 32'(g_cmd_ready), 32'd1);
        tick();
        check("g_held_cmd_v", 32'(g_pos_v), 32'd1);
        check("g_held_cmd_pos", 32'(g_pos_out), 32'(pt(4'd2, 5'd5)));
        g_cmd_v = 1'b0;
        g_cmd = eCmdNone;
        repeat (8) tick();
        check("g_ready_pending2", 32'(g_cmd_ready), 32'd0);
        check("g_no_strobe_pend2", 32'(g_pos_v), 32'd0);
        tick();
        check("g_grav_down2_v", 32'(g_pos_v), 32'd1);
        check("g_grav_down2_pos", 32'(g_pos_out), 32'(pt(4'd3, 5'd6)));

        // Main instance: reset values.
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_state", 32'(state), 32'(eStart));
        check("rst_pos", 32'(pos_out), 32'(pt(4'd3, 5'd0)));
        check("rst_type", 32'(type_out), 32'(eNon));
        check("rst_angle", 32'(angle_out), 32'd0);
        check("rst_strobes", 32'({pos_v, type_v, fetch, empty}), 32'd0);
        check("rst_commit", 32'(commit_v), 32'd0);
        check("rst_game_over", 32'(game_over), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);

        // Spawn of (eT, 2), fetch, judge wait.
        @(negedge clk);
        reset = 1'b0;
        repeat (2) tick();
        check("spawn_pos_v", 32'(pos_v), 32'd1);
        check("spawn_type_v", 32'(type_v), 32'd1);
        check("spawn_pos", 32'(pos_out), 32'(pt(4'd3, 5'd0)));
        check("spawn_type", 32'(type_out), 32'(eT));
        check("spawn_angle", 32'(angle_out), 32'd2);
        check("spawn_no_fetch", 32'(fetch), 32'd0);
        tick();
        check("fetch_pulse", 32'(fetch), 32'd1);
        check("fetch_no_strobe", 32'({pos_v, type_v}), 32'd0);
        repeat (4) tick();
        check("judge_min_wait", 32'(state), 32'(eWaitJudge));
        check("judge_fetch_single", 32'(fetch), 32'd0);
        tick();
        check("judge_to_run", 32'(state), 32'(eRun));

        for (int i = 0; i < n_vecs_c; i++) begin
            wait_run($sformatf("v%0d_run", i));
            @(negedge clk);
            pos_in = pt(vecs[i].x, vecs[i].y);
            angle_in = vecs[i].ang;
            avail = vecs[i].avail;
            cmd = vecs[i].cmd;
            cmd_v = 1'b1;
            #1;
            check($sformatf("v%0d_cmd_ready", i), 32'(cmd_ready), 32'd1);
            tick();
            cmd_v = 1'b0;
            cmd = eCmdNone;
            check($sformatf("v%0d_pos_v", i), 32'(pos_v), 32'(vecs[i].exp_pos_v));
            check($sformatf("v%0d_type_v", i), 32'(type_v), 32'(vecs[i].exp_type_v));
            check($sformatf("v%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
            check($sformatf("v%0d_angle", i), 32'(angle_out), 32'(vecs[i].exp_ang));
            check($sformatf("v%0d_type", i), 32'(type_out), 32'(eT));
            if (vecs[i].exp_pos_v)
                check($sformatf("v%0d_pos", i), 32'(pos_out), 32'(pt(vecs[i].exp_x, vecs[i].exp_y)));
        end

        // Lock at (4,10) with a stalled merge stage, then respawn of (eI, 1).
        wait_run("lock_run");
        @(negedge clk);
        pos_in = pt(4'd4, 5'd10);
        avail = 4'b1011;
        cmd = eCmdDown;
        cmd_v = 1'b1;
        tick();
        cmd_v = 1'b0;
        cmd = eCmdNone;
        next_type = eI;
        next_angle = 2'd1;
        check("lock_state", 32'(state), 32'(eLock));
        check("lock_commit_v", 32'(commit_v), 32'd1);
        check("lock_no_pos_v", 32'(pos_v), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("lock_hold%0d_commit", k), 32'(commit_v), 32'd1);
            check($sformatf("lock_hold%0d_empty", k), 32'(empty), 32'd0);
        end
        commit_ready = 1'b1;
        tick();
        commit_ready = 1'b0;
        check("hs_commit_drop", 32'(commit_v), 32'd0);
        check("hs_empty", 32'(empty), 32'd1);
        check("hs_state", 32'(state), 32'(eStart));
        tick();
        check("hs_empty_single", 32'(empty), 32'd0);
        check("hs_to_spawn", 32'(state), 32'(eSpawn));
        tick();
        check("respawn_strobes", 32'({pos_v, type_v}), 32'd3);
        check("respawn_pos", 32'(pos_out), 32'(pt(4'd3, 5'd0)));
        check("respawn_type", 32'(type_out), 32'(eI));
        check("respawn_angle", 32'(angle_out), 32'd1);

        // Blocked down on the spawn row ends the game.
        pos_in = pt(4'd3, 5'd0);
        type_in = eI;
        wait_run("over_run");
        @(negedge clk);
        cmd = eCmdDown;
        cmd_v = 1'b1;
        tick();
        check("over_state", 32'(state), 32'(eOver));
        check("over_flag", 32'(game_over), 32'd1);
        check("over_cmd_ready", 32'(cmd_ready), 32'd0);
        check("over_no_commit", 32'(commit_v), 32'd0);
        cmd = eCmdLeft;
        avail = 4'b1111;
        repeat (3) tick();
        check("over_sticky", 32'(game_over), 32'd1);
        check("over_no_strobe", 32'({pos_v, type_v, fetch, empty}), 32'd0);
        #2 reset = 1'b1;
        #1;
        check("over_async_clear", 32'(game_over), 32'd0);
        check("over_async_state", 32'(state), 32'(eStart));
        cmd_v = 1'b0;
        cmd = eCmdNone;

        // Reset in the middle of a commit handshake drops commit_v_o at once.
        @(negedge clk);
        reset = 1'b0;
        pos_in = pt(4'd4, 5'd10);
        avail = 4'b1011;
        wait_run("mid_run");
        @(negedge clk);
        cmd = eCmdDown;
        cmd_v = 1'b1;
        tick();
        cmd_v = 1'b0;
        cmd = eCmdNone;
        check("mid_commit_v", 32'(commit_v), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_commit", 32'(commit_v), 32'd0);
        check("mid_rst_state", 32'(state), 32'(eStart));
        check("mid_rst_empty", 32'(empty), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
